// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) pipeline stage register with valid/ready handshake,
// synchronous flush with bubble insertion and a saturating backpressure counter.
module pipe_stage_buf #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CTRL_W     = 16,
    parameter bit          FLUSH_DATA = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              main_valid;
    logic              ready_q;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [CNT_W-1:0]  cnt_q;

    logic acc;
    logic pop;

    assign acc = in_valid & ready_q;
    assign pop = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            main_valid <= 1'b0;
            ready_q    <= 1'b1;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            state      <= ST_EMPTY;
            main_valid <= 1'b0;
            ready_q    <= 1'b1;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
            if (FLUSH_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_data  <= in_data;
                        main_ctrl  <= in_ctrl;
                        main_valid <= 1'b1;
                        state      <= ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (pop && acc) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (pop) begin
                        main_valid <= 1'b0;
                        state      <= ST_EMPTY;
                    end else if (acc) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        ready_q   <= 1'b0;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no new entry can overtake the skid one.
                    if (pop) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        ready_q   <= 1'b1;
                        state     <= ST_MAIN;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    main_valid <= 1'b0;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (main_valid && !out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign occupancy = state;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed table-driven bench for pipe_stage_buf; a second instance with
// FLUSH_DATA=1 and a 4-bit counter shares the same stimulus.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_data,  out_data2;
    logic [15:0] out_ctrl,  out_ctrl2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt2;

    int unsigned n_cmp;
    int unsigned n_fail;

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(16), .FLUSH_DATA(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(16), .FLUSH_DATA(1'b1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [31:0] din;
        logic [15:0] cin;
        logic        ev;
        logic [15:0] ec;
        logic        er;
        logic [1:0]  eo;
        logic [15:0] es;
        logic        chkd;
        logic [31:0] ed;
        logic [31:0] ed2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic fl, logic ordy, logic [31:0] din, logic [15:0] cin,
                                logic ev, logic [15:0] ec, logic er, logic [1:0] eo, logic [15:0] es,
                                logic chkd, logic [31:0] ed, logic [31:0] ed2);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.din = din; v.cin = cin;
        v.ev = ev; v.ec = ec; v.er = er; v.eo = eo; v.es = es;
        v.chkd = chkd; v.ed = ed; v.ed2 = ed2;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: actual %0h required %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input int idx);
        chk("rst_out_valid", idx, 64'(out_valid), 64'd0);
        chk("rst_in_ready",  idx, 64'(in_ready),  64'd1);
        chk("rst_occupancy", idx, 64'(occupancy), 64'd0);
        chk("rst_out_ctrl",  idx, 64'(out_ctrl),  64'd0);
        chk("rst_out_data",  idx, 64'(out_data),  64'd0);
        chk("rst_stall_cnt", idx, 64'(stall_cnt), 64'd0);
        chk("rst_stall_cnt2", idx, 64'(stall_cnt2), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;

        // Streaming
        vecs.push_back(mk(1,0,1,32'h10,16'h1,  1,16'h1,1,2'd1,16'd0, 1,32'h10,32'h10));
        vecs.push_back(mk(1,0,1,32'h11,16'h2,  1,16'h2,1,2'd1,16'd0, 1,32'h11,32'h11));
        vecs.push_back(mk(1,0,1,32'h12,16'h3,  1,16'h3,1,2'd1,16'd0, 1,32'h12,32'h12));
        vecs.push_back(mk(1,0,1,32'h13,16'h4,  1,16'h4,1,2'd1,16'd0, 1,32'h13,32'h13));
        vecs.push_back(mk(0,0,1,32'h0, 16'h0,  0,16'h0,1,2'd0,16'd0, 0,32'h0, 32'h0));
        // Backpressure: A main, B skid, C refused until drained
        vecs.push_back(mk(1,0,0,32'hAA,16'hA,  1,16'hA,1,2'd1,16'd0, 1,32'hAA,32'hAA));
        vecs.push_back(mk(1,0,0,32'hBB,16'hB,  1,16'hA,0,2'd2,16'd1, 1,32'hAA,32'hAA));
        vecs.push_back(mk(1,0,0,32'hCC,16'hC,  1,16'hA,0,2'd2,16'd2, 1,32'hAA,32'hAA));
        vecs.push_back(mk(1,0,0,32'hCC,16'hC,  1,16'hA,0,2'd2,16'd3, 1,32'hAA,32'hAA));
        vecs.push_back(mk(1,0,1,32'hCC,16'hC,  1,16'hB,1,2'd1,16'd3, 1,32'hBB,32'hBB));
        vecs.push_back(mk(1,0,1,32'hCC,16'hC,  1,16'hC,1,2'd1,16'd3, 1,32'hCC,32'hCC));
        vecs.push_back(mk(0,0,1,32'h0, 16'h0,  0,16'h0,1,2'd0,16'd3, 0,32'h0, 32'h0));
        // Flush with occupancy 2 and D offered
        vecs.push_back(mk(1,0,0,32'hE0,16'h10, 1,16'h10,1,2'd1,16'd3, 1,32'hE0,32'hE0));
        vecs.push_back(mk(1,0,0,32'hE1,16'h11, 1,16'h10,0,2'd2,16'd4, 1,32'hE0,32'hE0));
        vecs.push_back(mk(1,1,0,32'hDD,16'hD,  0,16'h0,1,2'd0,16'd5, 1,32'hE0,32'h0));
        vecs.push_back(mk(0,0,1,32'h0, 16'h0,  0,16'h0,1,2'd0,16'd5, 1,32'hE0,32'h0));
        // Flush with occupancy 1, accepted D and a pop in the same cycle
        vecs.push_back(mk(1,0,1,32'hF0,16'h20, 1,16'h20,1,2'd1,16'd5, 1,32'hF0,32'hF0));
        vecs.push_back(mk(1,1,1,32'hDD,16'hD,  0,16'h0,1,2'd0,16'd5, 1,32'hF0,32'h0));
        vecs.push_back(mk(0,0,1,32'h0, 16'h0,  0,16'h0,1,2'd0,16'd5, 1,32'hF0,32'h0));
        vecs.push_back(mk(1,0,1,32'h77,16'h7,  1,16'h7,1,2'd1,16'd5, 1,32'h77,32'h77));
        vecs.push_back(mk(0,0,1,32'h0, 16'h0,  0,16'h0,1,2'd0,16'd5, 0,32'h0, 32'h0));

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk_reset_vals(-1);

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            in_data   = vecs[i].din;
            in_ctrl   = vecs[i].cin;
            step();
            chk("out_valid",  i, 64'(out_valid),  64'(vecs[i].ev));
            chk("out_ctrl",   i, 64'(out_ctrl),   64'(vecs[i].ec));
            chk("in_ready",   i, 64'(in_ready),   64'(vecs[i].er));
            chk("occupancy",  i, 64'(occupancy),  64'(vecs[i].eo));
            chk("stall_cnt",  i, 64'(stall_cnt),  64'(vecs[i].es));
            chk("stall_cnt2", i, 64'(stall_cnt2), 64'(vecs[i].es));
            chk("out_ctrl2",  i, 64'(out_ctrl2),  64'(vecs[i].ec));
            if (vecs[i].chkd) begin
                chk("out_data",  i, 64'(out_data),  64'(vecs[i].ed));
                chk("out_data2", i, 64'(out_data2), 64'(vecs[i].ed2));
            end
        end
        flush = 1'b0;

        // Saturation: 4-bit counter pins at 15, 16-bit one keeps counting
        in_valid = 1'b1; in_data = 32'h99; in_ctrl = 16'h9; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 9)  chk("sat_cnt2_k9",  k, 64'(stall_cnt2), 64'd14);
            if (k == 10) chk("sat_cnt2_k10", k, 64'(stall_cnt2), 64'd15);
        end
        chk("sat_cnt2_hold", 20, 64'(stall_cnt2), 64'd15);
        chk("sat_cnt_wide",  20, 64'(stall_cnt),  64'd25);
        chk("sat_out_data",  20, 64'(out_data),   64'h99);
        out_ready = 1'b1;
        step();
        chk("sat_drain_occ", 0, 64'(occupancy), 64'd0);
        chk("sat_drain_cnt", 0, 64'(stall_cnt), 64'd25);

        // Async reset with two entries held
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h31; in_ctrl = 16'h3;
        step();
        in_data = 32'h32; in_ctrl = 16'h4;
        step();
        in_valid = 1'b0;
        chk("pre_rst_occ",  0, 64'(occupancy), 64'd2);
        chk("pre_rst_cnt",  0, 64'(stall_cnt), 64'd26);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_vals(100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_reset_vals(101);
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h5; out_ready = 1'b1;
        step();
        chk("post_rst_valid", 0, 64'(out_valid), 64'd1);
        chk("post_rst_data",  0, 64'(out_data),  64'h55);
        chk("post_rst_ctrl",  0, 64'(out_ctrl),  64'h5);
        chk("post_rst_occ",   0, 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        step();
        chk("post_rst_alone_valid", 0, 64'(out_valid), 64'd0);
        chk("post_rst_alone_occ",   0, 64'(occupancy), 64'd0);
        chk("post_rst_alone_ctrl",  0, 64'(out_ctrl),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for the CPU datapath; the generalised replacement for the fixed-field stage registers between ID/EX/MEM/WB.
- Carries one opaque data bundle (DATA_W) and one control bundle (CTRL_W) with a valid/ready handshake in place of raw stall.
- Holds up to two entries (main + skid), so in_ready is a pure register output and the upstream ready path is broken every stage.
- Adds synchronous flush with bubble insertion and a saturating backpressure-cycle counter.

Parameters:
DATA_W, 32, width of the data bundle (operands, PC+4, immediate, concatenated by the instantiator)
CTRL_W, 16, width of the control bundle (opcode, reg_wr, mem_wr, etc.); all-zero is a NOP
FLUSH_DATA, 0, 1 = zero data registers on flush; 0 = hold data on flush to save power
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main entry data
out_ctrl  out  CTRL_W  main entry control; forced to 0 when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  saturating count of backpressure cycles

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - main_valid=0, skid_valid=0, so out_valid=0, in_ready=1, occupancy=0.
  - All data and ctrl registers = 0; stall_cnt=0.
- Handshake terms:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_data/in_ctrl are sampled only on acc. out_data is stable while out_valid & !out_ready.
- Next-state rules when flush=0:
  - main empty, acc: entry enters main. out_valid next cycle (1-cycle latency).
  - main full, pop, skid empty, acc: new entry replaces main (full throughput, 1 entry/cycle).
  - main full, pop, skid full: skid moves to main, skid_valid=0. in_ready is 0 that cycle, so acc cannot occur.
  - main full, no pop, acc: entry goes to skid, skid_valid=1, in_ready=0 next cycle.
  - main full, pop, no acc, skid empty: main_valid=0.
- Ordering: strict FIFO; the skid entry is never overtaken by a newer entry.
- occupancy = main_valid + skid_valid. skid_valid=1 implies main_valid=1.
- Flush (priority over everything except reset):
  - Next cycle main_valid=0, skid_valid=0, in_ready=1, occupancy=0.
  - Ctrl registers of both entries are zeroed.
  - Data registers are zeroed if FLUSH_DATA=1, otherwise held.
  - An acc in the flush cycle is discarded; the upstream sees a completed handshake and must account for the squash itself.
  - A pop in the flush cycle still completes downstream; the entry is consumed, not duplicated.
- Bubble: out_ctrl = main_valid ? main_ctrl : 0 (combinational gate). Downstream decoding of an invalid stage therefore sees a NOP.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Not affected by flush; cleared only by reset.
- Reset mid-operation: all entries are dropped immediately and asynchronously. No output glitches back to old data after release.
- No combinational path from in_* to out_*. No combinational path from out_ready to in_ready.

Test Plan:
- Post-reset idle: hold rst_n=0 then release -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, stall_cnt=0.
- Streaming: out_ready=1, push data 0x10..0x13 with ctrl 0x0001..0x0004 on consecutive cycles -> same sequence on out_* one cycle later, no gaps, occupancy stays 1.
- Backpressure: push A=0xAA, B=0xBB, C=0xCC with out_ready=0 ->
  - A held in main, B in skid, occupancy=2.
  - in_ready=0 from the cycle after B, and C is not accepted.
  - Raise out_ready -> A, B, C emerge in order.
  - stall_cnt equals the count of low-ready cycles with out_valid=1.
- Flush with occupancy=2 and a simultaneous in_valid (D=0xDD) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, D never appears. Repeat with FLUSH_DATA=1 -> out_data=0.
- Saturation: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Async reset mid-transfer: assert rst_n=0 between clock edges while occupancy=2 -> outputs return to reset values immediately. After release the first pushed entry 0x55 emerges alone.
